// File: rtl/eth_rx_frame_fifo.sv
// rtl/eth_rx_frame_fifo.sv - single-clock Ethernet RX frame buffer with commit/rollback and frame-length queue

typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [31:0] data;
    logic [2:0]  bytes_valid;
    logic        commit;
    logic        drop;
} EthernetRxBus;

module eth_rx_frame_fifo #(
    parameter int DEPTH         = 4096,
    parameter int HEADER_DEPTH  = 32,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int LEN_WIDTH     = $clog2(MAX_FRAME_LEN + 1),
    parameter int HEADROOM      = (MAX_FRAME_LEN + 3) / 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  EthernetRxBus             rx_bus,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_offset,
    output logic [31:0]              rd_data,
    input  logic                     rd_pop_single,
    input  logic                     rd_pop_packet,
    input  logic [$clog2(DEPTH):0]   rd_packet_words,
    input  logic                     header_rd_en,
    output logic                     header_rd_empty,
    output logic [LEN_WIDTH-1:0]     header_rd_data,
    output logic [31:0]              drop_count,
    output logic [31:0]              trunc_count,
    output logic [$clog2(DEPTH):0]   wr_free
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int HAW = $clog2(HEADER_DEPTH);
    localparam int FW  = LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RECEIVING, DROPPING} wr_state_t;

    wr_state_t            state_q, state_d;
    logic [PW-1:0]        wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0]        used, free, avail, pop_amount;
    logic [AW-1:0]        rd_addr;
    logic [LEN_WIDTH-1:0] framelen, commit_len;
    logic [FW-1:0]        framelen_next;
    logic                 frame_begin, rollback, wr_inc, commit_do, drop_inc, trunc_inc;
    logic                 hq_full, hq_empty, hq_pop;
    logic [HAW:0]         hq_wr, hq_rd;
    logic [LEN_WIDTH-1:0] hq_mem [HEADER_DEPTH];
    logic [31:0]          mem [DEPTH];

    // Free space includes uncommitted words so an in-flight frame cannot overrun unread data.
    assign used          = wr_ptr - rd_ptr;
    assign free          = PW'(DEPTH) - used;
    assign wr_free       = free;
    assign framelen_next = {1'b0, framelen} + FW'(rx_bus.bytes_valid);
    assign commit_len    = wr_inc ? framelen_next[LEN_WIDTH-1:0] : framelen;
    assign rd_addr       = rd_ptr[AW-1:0] + rd_offset;
    assign avail         = commit_ptr - rd_ptr;
    assign pop_amount    = rd_pop_packet ? rd_packet_words : PW'(1);

    assign hq_empty        = (hq_wr == hq_rd);
    assign hq_full         = (hq_wr[HAW] != hq_rd[HAW]) && (hq_wr[HAW-1:0] == hq_rd[HAW-1:0]);
    assign hq_pop          = header_rd_en && !hq_empty;
    assign header_rd_empty = hq_empty;
    assign header_rd_data  = hq_empty ? '0 : hq_mem[hq_rd[HAW-1:0]];

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Write FSM decode: start overrides everything, drop beats commit, truncation beats commit.
    always_comb begin
        state_d     = state_q;
        frame_begin = 1'b0;
        rollback    = 1'b0;
        wr_inc      = 1'b0;
        commit_do   = 1'b0;
        drop_inc    = 1'b0;
        trunc_inc   = 1'b0;
        if (rx_bus.start) begin
            if (free < PW'(HEADROOM + 1) || hq_full) begin
                state_d  = DROPPING;
                drop_inc = 1'b1;
            end else begin
                state_d     = RECEIVING;
                frame_begin = 1'b1;
            end
        end else begin
            case (state_q)
                RECEIVING: begin
                    if (rx_bus.drop) begin
                        rollback = 1'b1;
                        state_d  = DROPPING;
                    end else if (rx_bus.data_valid &&
                                 (free == '0 || framelen_next > FW'(MAX_FRAME_LEN))) begin
                        rollback  = 1'b1;
                        trunc_inc = 1'b1;
                        state_d   = DROPPING;
                    end else begin
                        wr_inc = rx_bus.data_valid;
                        if (rx_bus.commit) begin
                            commit_do = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
                DROPPING: begin
                    if (rx_bus.commit || rx_bus.drop) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    // Write/commit pointers and running frame length.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            framelen   <= '0;
        end else begin
            if (frame_begin || rollback) wr_ptr <= commit_ptr;
            else if (wr_inc)             wr_ptr <= wr_ptr + 1'b1;
            if (frame_begin)             framelen <= '0;
            else if (wr_inc)             framelen <= framelen_next[LEN_WIDTH-1:0];
            if (commit_do)               commit_ptr <= wr_ptr + PW'(wr_inc);
        end
    end

    // Data buffer write port.
    always_ff @(posedge clk) begin
        if (wr_inc) mem[wr_ptr[AW-1:0]] <= rx_bus.data;
    end

    // Registered random-offset read; holds when rd_en is low.
    always_ff @(posedge clk) begin
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

    // Read pointer release, clamped so it never passes the committed data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (rd_pop_single || rd_pop_packet) begin
            rd_ptr <= (pop_amount > avail) ? commit_ptr : rd_ptr + pop_amount;
        end
    end

    // Frame-length queue pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hq_wr <= '0;
            hq_rd <= '0;
        end else begin
            if (commit_do) hq_wr <= hq_wr + 1'b1;
            if (hq_pop)    hq_rd <= hq_rd + 1'b1;
        end
    end

    // Frame-length queue storage.
    always_ff @(posedge clk) begin
        if (commit_do) hq_mem[hq_wr[HAW-1:0]] <= commit_len;
    end

    // Saturating drop/truncation statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count  <= '0;
            trunc_count <= '0;
        end else begin
            if (drop_inc && drop_count != '1)   drop_count  <= drop_count + 1'b1;
            if (trunc_inc && trunc_count != '1) trunc_count <= trunc_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb/tb_eth_rx_frame_fifo.sv - directed self-checking bench for eth_rx_frame_fifo

module tb_eth_rx_frame_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [38:0] rx_bus;
    logic        rd_en;
    logic [11:0] rd_offset;
    logic [31:0] rd_data;
    logic        rd_pop_single;
    logic        rd_pop_packet;
    logic [12:0] rd_packet_words;
    logic        header_rd_en;
    logic        header_rd_empty;
    logic [10:0] header_rd_data;
    logic [31:0] drop_count;
    logic [31:0] trunc_count;
    logic [12:0] wr_free;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    eth_rx_frame_fifo dut (
        .clk             (clk),
        .reset           (reset),
        .rx_bus          (rx_bus),
        .rd_en           (rd_en),
        .rd_offset       (rd_offset),
        .rd_data         (rd_data),
        .rd_pop_single   (rd_pop_single),
        .rd_pop_packet   (rd_pop_packet),
        .rd_packet_words (rd_packet_words),
        .header_rd_en    (header_rd_en),
        .header_rd_empty (header_rd_empty),
        .header_rd_data  (header_rd_data),
        .drop_count      (drop_count),
        .trunc_count     (trunc_count),
        .wr_free         (wr_free)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rx_bus          = '0;
        rd_en           = 1'b0;
        rd_offset       = '0;
        rd_pop_single   = 1'b0;
        rd_pop_packet   = 1'b0;
        rd_packet_words = '0;
        header_rd_en    = 1'b0;
    endtask

    task automatic bus(input logic st, input logic dv, input logic [31:0] d,
                       input logic [2:0] bv, input logic cm, input logic dr);
        rx_bus = {st, dv, d, bv, cm, dr};
        tick();
        rx_bus = '0;
    endtask

    task automatic send_words(input int nwords, input logic [31:0] base);
        for (int i = 0; i < nwords; i++) bus(1'b0, 1'b1, base + 32'(i), 3'd4, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int nwords, input logic [2:0] last_bv, input logic [31:0] base);
        bus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        send_words(nwords - 1, base);
        bus(1'b0, 1'b1, base + 32'(nwords - 1), last_bv, 1'b1, 1'b0);
    endtask

    task automatic pop(input logic hdr, input logic [12:0] words);
        header_rd_en    = hdr;
        rd_pop_packet   = 1'b1;
        rd_packet_words = words;
        tick();
        clear_inputs();
    endtask

    task automatic read_word(input logic [11:0] off);
        rd_en     = 1'b1;
        rd_offset = off;
        tick();
        rd_en     = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        tests_run++; if (header_rd_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", header_rd_empty); end
        tests_run++; if (header_rd_data !== 11'd0) begin tests_failed++; $display("FAIL reset_hdr_data: got %0d expected 0", header_rd_data); end
        tests_run++; if (drop_count !== 32'd0) begin tests_failed++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
        tests_run++; if (trunc_count !== 32'd0) begin tests_failed++; $display("FAIL reset_trunc: got %0d expected 0", trunc_count); end
        tests_run++; if (wr_free !== 13'd4096) begin tests_failed++; $display("FAIL reset_wr_free: got %0d expected 4096", wr_free); end
    endtask

    task automatic test_single_frame();
        bus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        send_words(16, 32'hA000_0000);
        bus(1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        tests_run++; if (header_rd_empty !== 1'b0) begin tests_failed++; $display("FAIL single_empty: got %b expected 0", header_rd_empty); end
        tests_run++; if (header_rd_data !== 11'd64) begin tests_failed++; $display("FAIL single_len: got %0d expected 64", header_rd_data); end
        tests_run++; if (wr_free !== 13'd4080) begin tests_failed++; $display("FAIL single_wr_free: got %0d expected 4080", wr_free); end
        for (int i = 0; i < 16; i++) begin
            read_word(12'(i));
            tests_run++;
            if (rd_data !== 32'hA000_0000 + 32'(i)) begin
                tests_failed++; $display("FAIL single_read[%0d]: got %h expected %h", i, rd_data, 32'hA000_0000 + 32'(i));
            end
        end
        tick();
        tests_run++; if (rd_data !== 32'hA000_000F) begin tests_failed++; $display("FAIL single_hold: got %h expected a000000f", rd_data); end
        pop(1'b1, 13'd16);
        tests_run++; if (wr_free !== 13'd4096) begin tests_failed++; $display("FAIL single_pop_free: got %0d expected 4096", wr_free); end
        tests_run++; if (header_rd_empty !== 1'b1) begin tests_failed++; $display("FAIL single_pop_empty: got %b expected 1", header_rd_empty); end
    endtask

    task automatic test_commit_same_cycle();
        send_frame(16, 3'd1, 32'hB000_0000);
        tests_run++; if (header_rd_data !== 11'd61) begin tests_failed++; $display("FAIL same_cycle_len: got %0d expected 61", header_rd_data); end
        tests_run++; if (wr_free !== 13'd4080) begin tests_failed++; $display("FAIL same_cycle_free: got %0d expected 4080", wr_free); end
        read_word(12'd15);
        tests_run++; if (rd_data !== 32'hB000_000F) begin tests_failed++; $display("FAIL same_cycle_last: got %h expected b000000f", rd_data); end
        pop(1'b1, 13'd16);
        tests_run++; if (wr_free !== 13'd4096) begin tests_failed++; $display("FAIL same_cycle_pop: got %0d expected 4096", wr_free); end
    endtask

    task automatic test_mac_drop();
        bus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        send_words(10, 32'hD000_0000);
        bus(1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1);
        tests_run++; if (header_rd_empty !== 1'b1) begin tests_failed++; $display("FAIL drop_empty: got %b expected 1", header_rd_empty); end
        tests_run++; if (wr_free !== 13'd4096) begin tests_failed++; $display("FAIL drop_free: got %0d expected 4096", wr_free); end
        tests_run++; if (drop_count !== 32'd0) begin tests_failed++; $display("FAIL drop_dcount: got %0d expected 0", drop_count); end
        tests_run++; if (trunc_count !== 32'd0) begin tests_failed++; $display("FAIL drop_tcount: got %0d expected 0", trunc_count); end
        send_frame(4, 3'd4, 32'hE000_0000);
        tests_run++; if (header_rd_data !== 11'd16) begin tests_failed++; $display("FAIL drop_next_len: got %0d expected 16", header_rd_data); end
        read_word(12'd0);
        tests_run++; if (rd_data !== 32'hE000_0000) begin tests_failed++; $display("FAIL drop_next_data: got %h expected e0000000", rd_data); end
        pop(1'b1, 13'd4);
    endtask

    task automatic test_headroom();
        logic [10:0] exp_len;
        for (int f = 0; f < 9; f++) send_frame(379, 3'd4, 32'h0);
        send_frame(305, 3'd4, 32'h0);
        tests_run++; if (wr_free !== 13'd380) begin tests_failed++; $display("FAIL headroom_fill: got %0d expected 380", wr_free); end
        bus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        tests_run++; if (drop_count !== 32'd1) begin tests_failed++; $display("FAIL headroom_drop: got %0d expected 1", drop_count); end
        bus(1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        tests_run++; if (wr_free !== 13'd380) begin tests_failed++; $display("FAIL headroom_nohdr_free: got %0d expected 380", wr_free); end
        pop(1'b1, 13'd379);
        tests_run++; if (wr_free !== 13'd759) begin tests_failed++; $display("FAIL headroom_pop: got %0d expected 759", wr_free); end
        send_frame(1, 3'd4, 32'h5555_0000);
        tests_run++; if (drop_count !== 32'd1) begin tests_failed++; $display("FAIL headroom_accept_drop: got %0d expected 1", drop_count); end
        tests_run++; if (wr_free !== 13'd758) begin tests_failed++; $display("FAIL headroom_accept_free: got %0d expected 758", wr_free); end
        pop(1'b0, 13'd4096);
        tests_run++; if (wr_free !== 13'd4096) begin tests_failed++; $display("FAIL headroom_clamp: got %0d expected 4096", wr_free); end
        for (int i = 0; i < 10; i++) begin
            exp_len = (i < 8) ? 11'd1516 : ((i == 8) ? 11'd1220 : 11'd4);
            tests_run++;
            if (header_rd_data !== exp_len) begin
                tests_failed++; $display("FAIL headroom_hdr[%0d]: got %0d expected %0d", i, header_rd_data, exp_len);
            end
            header_rd_en = 1'b1;
            tick();
            header_rd_en = 1'b0;
        end
        tests_run++; if (header_rd_empty !== 1'b1) begin tests_failed++; $display("FAIL headroom_drained: got %b expected 1", header_rd_empty); end
    endtask

    task automatic test_trunc();
        bus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        send_words(379, 32'h0);
        bus(1'b0, 1'b1, 32'h0, 3'd3, 1'b1, 1'b0);
        tests_run++; if (trunc_count !== 32'd1) begin tests_failed++; $display("FAIL trunc_count: got %0d expected 1", trunc_count); end
        tests_run++; if (header_rd_empty !== 1'b1) begin tests_failed++; $display("FAIL trunc_empty: got %b expected 1", header_rd_empty); end
        tests_run++; if (wr_free !== 13'd4096) begin tests_failed++; $display("FAIL trunc_rollback: got %0d expected 4096", wr_free); end
        send_frame(380, 3'd2, 32'h0);
        tests_run++; if (header_rd_data !== 11'd1518) begin tests_failed++; $display("FAIL max_len: got %0d expected 1518", header_rd_data); end
        tests_run++; if (trunc_count !== 32'd1) begin tests_failed++; $display("FAIL max_trunc: got %0d expected 1", trunc_count); end
        tests_run++; if (wr_free !== 13'd3716) begin tests_failed++; $display("FAIL max_free: got %0d expected 3716", wr_free); end
        pop(1'b1, 13'd380);
    endtask

    task automatic test_header_full();
        logic [10:0] exp_len;
        for (int i = 0; i < 32; i++) send_frame(1, 3'((i % 4) + 1), 32'(i));
        tests_run++; if (wr_free !== 13'd4064) begin tests_failed++; $display("FAIL hfull_free: got %0d expected 4064", wr_free); end
        tests_run++; if (header_rd_data !== 11'd1) begin tests_failed++; $display("FAIL hfull_first: got %0d expected 1", header_rd_data); end
        bus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        tests_run++; if (drop_count !== 32'd2) begin tests_failed++; $display("FAIL hfull_drop: got %0d expected 2", drop_count); end
        bus(1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        header_rd_en = 1'b1;
        tick();
        header_rd_en = 1'b0;
        bus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        bus(1'b0, 1'b1, 32'h7700_0000, 3'd4, 1'b0, 1'b0);
        header_rd_en = 1'b1;
        bus(1'b0, 1'b1, 32'h7700_0001, 3'd3, 1'b1, 1'b0);
        header_rd_en = 1'b0;
        tests_run++; if (drop_count !== 32'd2) begin tests_failed++; $display("FAIL hfull_accept: got %0d expected 2", drop_count); end
        for (int i = 2; i < 33; i++) begin
            exp_len = (i < 32) ? 11'((i % 4) + 1) : 11'd7;
            tests_run++;
            if (header_rd_data !== exp_len) begin
                tests_failed++; $display("FAIL hfull_order[%0d]: got %0d expected %0d", i, header_rd_data, exp_len);
            end
            header_rd_en = 1'b1;
            tick();
            header_rd_en = 1'b0;
        end
        tests_run++; if (header_rd_empty !== 1'b1) begin tests_failed++; $display("FAIL hfull_drained: got %b expected 1", header_rd_empty); end
        tests_run++; if (wr_free !== 13'd4062) begin tests_failed++; $display("FAIL hfull_used: got %0d expected 4062", wr_free); end
        rd_pop_single = 1'b1;
        tick();
        rd_pop_single = 1'b0;
        tests_run++; if (wr_free !== 13'd4063) begin tests_failed++; $display("FAIL pop_single: got %0d expected 4063", wr_free); end
        rd_pop_single   = 1'b1;
        rd_pop_packet   = 1'b1;
        rd_packet_words = 13'd33;
        tick();
        clear_inputs();
        tests_run++; if (wr_free !== 13'd4096) begin tests_failed++; $display("FAIL pop_priority: got %0d expected 4096", wr_free); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(1, 3'd4, 32'h1234_5678);
        read_word(12'd0);
        tests_run++; if (rd_data !== 32'h1234_5678) begin tests_failed++; $display("FAIL midrst_pre_read: got %h expected 12345678", rd_data); end
        bus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        send_words(3, 32'h9900_0000);
        reset = 1'b1;
        bus(1'b0, 1'b1, 32'h9900_0003, 3'd4, 1'b0, 1'b0);
        reset = 1'b0;
        tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL midrst_rd_data: got %h expected 0", rd_data); end
        tests_run++; if (header_rd_empty !== 1'b1) begin tests_failed++; $display("FAIL midrst_empty: got %b expected 1", header_rd_empty); end
        tests_run++; if (header_rd_data !== 11'd0) begin tests_failed++; $display("FAIL midrst_hdr: got %0d expected 0", header_rd_data); end
        tests_run++; if (drop_count !== 32'd0) begin tests_failed++; $display("FAIL midrst_drop: got %0d expected 0", drop_count); end
        tests_run++; if (trunc_count !== 32'd0) begin tests_failed++; $display("FAIL midrst_trunc: got %0d expected 0", trunc_count); end
        tests_run++; if (wr_free !== 13'd4096) begin tests_failed++; $display("FAIL midrst_free: got %0d expected 4096", wr_free); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_frame();
        test_commit_same_cycle();
        test_mac_drop();
        test_headroom();
        test_trunc();
        test_header_full();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_fifo.md
# eth_rx_frame_fifo

Single-clock, parametrised Ethernet receive frame buffer with commit/rollback semantics and a companion frame-length queue. It accepts an `EthernetRxBus` stream from a MAC, stores accepted frames word-by-word, and publishes each frame's byte length only once the whole frame has been committed. Downstream logic reads frames with random-offset access and either single-word or whole-frame pops. Drop and truncation statistics are reported. It replaces the dual-clock management RX buffer wherever MAC and consumer share `clk`.

## Interface
- `DEPTH`, 4096: data buffer depth in 32-bit words; power of 2, ≥ 512.
- `HEADER_DEPTH`, 32: frame-length queue depth; power of 2.
- `MAX_FRAME_LEN`, 1518: largest accepted frame in bytes.
- `LEN_WIDTH`, derived = $clog2(MAX_FRAME_LEN+1): length field width.
- `HEADROOM`, derived = ceil(MAX_FRAME_LEN/4): free words required to accept a frame.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `rx_bus`  in  EthernetRxBus  fields: start, data_valid, data[31:0], bytes_valid[2:0] (1–4), commit, drop.
- `rd_en`  in  1  read request.
- `rd_offset`  in  $clog2(DEPTH)  word offset from the read pointer.
- `rd_data`  out  32  read word.
- `rd_pop_single`  in  1  advance the read pointer by 1 word.
- `rd_pop_packet`  in  1  advance the read pointer by `rd_packet_words`.
- `rd_packet_words`  in  $clog2(DEPTH)+1  words to release.
- `header_rd_en`  in  1  pop the frame-length queue.
- `header_rd_empty`  out  1  frame-length queue is empty.
- `header_rd_data`  out  LEN_WIDTH  byte length of the oldest committed frame (first-word fall-through).
- `drop_count`  out  32  frames rejected for lack of space or header slot; saturating.
- `trunc_count`  out  32  frames aborted for exceeding MAX_FRAME_LEN or running out of space mid-frame; saturating.
- `wr_free`  out  $clog2(DEPTH)+1  free words, computed against the committed read pointer.

## Operation
- Pointers are `wr_ptr`, `commit_ptr` and `rd_ptr`, each $clog2(DEPTH)+1 bits wide and wrapping modulo 2·DEPTH.
- `free = DEPTH − (wr_ptr − rd_ptr)`, using modular subtraction.
- Write FSM has three states: IDLE, RECEIVING, DROPPING.
- `start` is evaluated in any state and has priority over every other write event in that cycle.
  - If `free < HEADROOM+1` or the header queue is full: go to DROPPING and increment `drop_count`.
  - Otherwise: go to RECEIVING, set `wr_ptr <= commit_ptr` (discarding any uncommitted partial frame) and set `framelen <= 0`.
- In RECEIVING, on `data_valid`:
  - If `free == 0` or `framelen + bytes_valid > MAX_FRAME_LEN`: roll back (`wr_ptr <= commit_ptr`), go to DROPPING and increment `trunc_count`.
  - Otherwise: write `data` at `wr_ptr`, increment `wr_ptr`, and add `bytes_valid` to `framelen`.
- In RECEIVING, on `drop`: roll back and go to DROPPING. No counter is incremented (the MAC flagged the error).
- In RECEIVING, on `commit`: set `commit_ptr <= wr_ptr` (this includes a word written in the same cycle) and push `framelen` (including that word) into the header queue. Go to IDLE.
- `commit` and `drop` in the same cycle: `drop` wins.
- In IDLE or DROPPING, `data_valid`, `commit` and `drop` are ignored. DROPPING returns to IDLE on `commit` or `drop`.
- Read side:
  - `rd_en` reads `mem[rd_ptr + rd_offset]` modulo DEPTH.
  - `rd_pop_single` and `rd_pop_packet` advance `rd_ptr`. If both are asserted, `rd_pop_packet` wins.
  - Popping beyond `commit_ptr` is a protocol violation. The block clamps `rd_ptr` to `commit_ptr`.
- Header queue: first-word fall-through. `header_rd_en` while empty is ignored.
- A push and a pop in the same cycle are both honoured. When the queue is full, this keeps occupancy unchanged.

## Timing
- `rd_data` has 1-cycle latency: `rd_en` at cycle N gives valid data at N+1. `rd_data` holds its value while `rd_en` is low.
- A pop at cycle N is visible in `rd_ptr` and `wr_free` at N+1.
- A committed frame is visible at N+1 after `commit` at N: `header_rd_empty` falls and `header_rd_data` is valid.
- `drop_count` and `trunc_count` update 1 cycle after the triggering event.
- A same-cycle read of the word being written returns the old memory content. This is acceptable, because uncommitted data is never legally read.
- Reset values:
  - `rd_data` = 0, `header_rd_empty` = 1, `header_rd_data` = 0.
  - Both counters = 0, `wr_free` = DEPTH.
  - FSM = IDLE, all pointers = 0.
- Reset mid-frame discards every frame, committed or not, and any partial frame.

## Test plan
- Single 64-byte frame: start, 16 words, then commit → `header_rd_data`=64 one cycle later. Reading offsets 0–15 returns the words in order. `rd_pop_packet` with 16 words brings `wr_free` back to 4096.
- 61-byte frame (last word with `bytes_valid`=1) committed on the cycle of the final `data_valid` → length 61, 16 words stored.
- MAC `drop` after 10 words → no header pushed, `wr_free` unchanged, counters unchanged. The next frame is stored at the former `commit_ptr`.
- Fill until `wr_free` = 380 (HEADROOM=380, so the requirement is 381), then start → `drop_count`=1, no header. Pop one frame, then start → accepted.
- Frame with 1519 bytes (MAX_FRAME_LEN=1518) → `trunc_count`=1, no header, `wr_ptr` rolled back.
- Push 32 committed frames with HEADER_DEPTH=32, then a 33rd → `drop_count` increments. Simultaneous `header_rd_en` and commit while full keeps the queue full with correct ordering. A reset asserted mid-frame gives all reset values on the next cycle.
